// File: rtl/c1541_track_sched.sv
// c1541_track_sched: decodes stepper phases into a half-track position and, once the
// head has settled, schedules SD write-back of a dirty track followed by a load of the new one.
module c1541_track_sched #(
    parameter int SETTLE_TICKS     = 2000,
    parameter int MAX_HALF_TRACK   = 83,
    parameter int RESET_HALF_TRACK = 34
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic [1:0] i_stp,
    input  logic       i_mtr,
    input  logic       i_img_mounted,
    input  logic       i_img_present,
    input  logic       i_dirty_set,
    input  logic       i_sd_ack,
    output logic [6:0] o_half_track,
    output logic       o_tr00_sense_n,
    output logic       o_busy,
    output logic       o_sd_rd,
    output logic       o_sd_wr,
    output logic [5:0] o_sd_track
);
    localparam int CW = $clog2(SETTLE_TICKS + 1);
    typedef enum logic [1:0] {IDLE, SETTLE, SAVE, LOAD} state_t;
    state_t          r_state;
    logic [6:0]      r_half_track;
    logic [1:0]      r_prev_stp;
    logic [CW-1:0]   r_cnt;
    logic [5:0]      r_loaded_track;
    logic [5:0]      r_sd_track;
    logic            r_loaded_valid;
    logic            r_dirty;
    logic            r_stale;
    logic            r_sd_rd;
    logic            r_sd_wr;
    logic [1:0]      w_stp_inc;
    logic [1:0]      w_stp_dec;
    logic            w_fwd;
    logic            w_bwd;
    logic            w_step;
    logic            w_need_load;
    logic            w_load_done;
    assign w_stp_inc   = r_prev_stp + 2'd1;
    assign w_stp_dec   = r_prev_stp - 2'd1;
    assign w_fwd       = i_ce & i_mtr & (i_stp == w_stp_inc);
    assign w_bwd       = i_ce & i_mtr & (i_stp == w_stp_dec);
    assign w_step      = w_fwd | w_bwd;
    assign w_need_load = i_img_present & (~r_loaded_valid | (r_loaded_track != r_half_track[6:1]));
    assign w_load_done = (r_state == LOAD) & r_sd_rd & i_sd_ack;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_half_track   <= 7'(RESET_HALF_TRACK);
            r_prev_stp     <= 2'd0;
            r_cnt          <= '0;
            r_loaded_track <= 6'd0;
            r_sd_track     <= 6'd0;
            r_loaded_valid <= 1'b0;
            r_dirty        <= 1'b0;
            r_stale        <= 1'b0;
            r_sd_rd        <= 1'b0;
            r_sd_wr        <= 1'b0;
        end else begin
            if (i_ce)
                r_prev_stp <= i_stp;
            if (w_fwd && r_half_track != 7'(MAX_HALF_TRACK))
                r_half_track <= r_half_track + 7'd1;
            else if (w_bwd && r_half_track != 7'd0)
                r_half_track <= r_half_track - 7'd1;
            case (r_state)
                IDLE: begin
                    if (i_dirty_set && r_loaded_valid)
                        r_dirty <= 1'b1;
                    if (w_need_load) begin
                        r_state <= SETTLE;
                        r_cnt   <= CW'(SETTLE_TICKS);
                    end
                end
                SETTLE: begin
                    if (w_step)
                        r_cnt <= CW'(SETTLE_TICKS);
                    else if (r_cnt == '0) begin
                        if (!w_need_load)
                            r_state <= IDLE;
                        else if (r_dirty && r_loaded_valid) begin
                            r_state    <= SAVE;
                            r_sd_track <= r_loaded_track;
                        end else begin
                            r_state    <= LOAD;
                            r_sd_track <= r_half_track[6:1];
                        end
                    end else if (i_ce)
                        r_cnt <= r_cnt - 1'b1;
                end
                SAVE: begin
                    if (r_sd_wr && i_sd_ack) begin
                        r_sd_wr    <= 1'b0;
                        r_dirty    <= 1'b0;
                        r_state    <= LOAD;
                        r_sd_track <= r_half_track[6:1];
                    end else
                        r_sd_wr <= 1'b1;
                end
                LOAD: begin
                    if (w_load_done) begin
                        r_sd_rd        <= 1'b0;
                        r_loaded_track <= r_sd_track;
                        r_loaded_valid <= ~(r_stale | i_img_mounted);
                        r_stale        <= 1'b0;
                        r_state        <= IDLE;
                    end else
                        r_sd_rd <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            // a mount during a transfer lets it finish but marks its data as belonging to the old image
            if (i_img_mounted) begin
                r_loaded_valid <= 1'b0;
                r_dirty        <= 1'b0;
                if (r_state == SAVE || (r_state == LOAD && !w_load_done))
                    r_stale <= 1'b1;
            end
        end
    end
    assign o_half_track   = r_half_track;
    assign o_tr00_sense_n = |r_half_track;
    assign o_busy         = r_state != IDLE;
    assign o_sd_rd        = r_sd_rd;
    assign o_sd_wr        = r_sd_wr;
    assign o_sd_track     = r_sd_track;
endmodule

// File: tb/tb_c1541_track_sched.sv
// tb_c1541_track_sched: vector table for step decode, directed SD scheduling sequences,
// and a randomized run against an arithmetic half-track model plus handshake rules.
module tb_c1541_track_sched;
    localparam int ST   = 50;
    localparam int MAXH = 83;
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_ce = 1'b1;
    logic [1:0] i_stp = 2'd0;
    logic       i_mtr = 1'b0;
    logic       i_img_mounted = 1'b0;
    logic       i_img_present = 1'b1;
    logic       i_dirty_set = 1'b0;
    logic       i_sd_ack = 1'b0;
    logic [6:0] o_half_track;
    logic       o_tr00_sense_n;
    logic       o_busy;
    logic       o_sd_rd;
    logic       o_sd_wr;
    logic [5:0] o_sd_track;
    int checks = 0;
    int errors = 0;

    c1541_track_sched #(.SETTLE_TICKS(ST), .MAX_HALF_TRACK(MAXH), .RESET_HALF_TRACK(34)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_stp(i_stp), .i_mtr(i_mtr),
        .i_img_mounted(i_img_mounted), .i_img_present(i_img_present), .i_dirty_set(i_dirty_set),
        .i_sd_ack(i_sd_ack), .o_half_track(o_half_track), .o_tr00_sense_n(o_tr00_sense_n),
        .o_busy(o_busy), .o_sd_rd(o_sd_rd), .o_sd_wr(o_sd_wr), .o_sd_track(o_sd_track)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0] stp;
        logic       mtr;
        logic       ce;
        int         half;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic step(input logic [1:0] s);
        i_stp = s;
        tick();
    endtask

    task automatic pulse_dirty;
        i_dirty_set = 1'b1;
        tick();
        i_dirty_set = 1'b0;
    endtask

    task automatic pulse_mount;
        i_img_mounted = 1'b1;
        tick();
        i_img_mounted = 1'b0;
    endtask

    task automatic do_reset(input logic pres);
        i_reset = 1'b1;
        i_img_present = pres;
        i_stp = 2'd0;
        i_mtr = 1'b0;
        i_ce = 1'b1;
        i_dirty_set = 1'b0;
        i_img_mounted = 1'b0;
        i_sd_ack = 1'b0;
        repeat (2) tick();
        i_reset = 1'b0;
    endtask

    task automatic serve(input logic exp_wr, input int exp_track, input string name,
                         input logic do_ack, output int lat);
        lat = 0;
        while (!(o_sd_rd | o_sd_wr) && lat < 20 * ST) begin
            tick();
            lat++;
        end
        check({name, "_seen"}, int'(o_sd_rd | o_sd_wr), 1);
        check({name, "_kind_wr"}, int'(o_sd_wr), int'(exp_wr));
        check({name, "_both"}, int'(o_sd_rd & o_sd_wr), 0);
        check({name, "_track"}, int'(o_sd_track), exp_track);
        if (do_ack && (o_sd_rd | o_sd_wr)) begin
            i_sd_ack = 1'b1;
            tick();
            i_sd_ack = 1'b0;
            check({name, "_drop"}, int'(o_sd_rd | o_sd_wr), 0);
        end
    endtask

    initial begin
        int lat;
        logic [1:0] cur;
        int mh;
        logic [1:0] mp;
        logic [1:0] d;
        logic ord, owr, ack;
        logic [5:0] otr;
        int r;
        tbl = '{
            '{2'd1, 1'b1, 1'b1, 35}, '{2'd2, 1'b1, 1'b1, 36}, '{2'd3, 1'b1, 1'b1, 37},
            '{2'd0, 1'b1, 1'b1, 38}, '{2'd2, 1'b1, 1'b1, 38}, '{2'd1, 1'b1, 1'b1, 37},
            '{2'd0, 1'b1, 1'b1, 36}, '{2'd1, 1'b0, 1'b1, 36}, '{2'd1, 1'b1, 1'b1, 36},
            '{2'd2, 1'b1, 1'b0, 36}, '{2'd2, 1'b1, 1'b1, 37}, '{2'd1, 1'b1, 1'b1, 36}
        };

        // reset state, then first load of track 17 after the settle time
        repeat (2) tick();
        check("rst_half", int'(o_half_track), 34);
        check("rst_busy", int'(o_busy), 0);
        check("rst_rd", int'(o_sd_rd), 0);
        check("rst_wr", int'(o_sd_wr), 0);
        check("rst_track", int'(o_sd_track), 0);
        check("rst_tr00", int'(o_tr00_sense_n), 1);
        i_reset = 1'b0;
        serve(1'b0, 17, "init_load", 1'b1, lat);
        check("init_lat", int'(lat >= ST && lat <= ST + 5), 1);
        check("init_idle", int'(o_busy), 0);

        // four inward steps to half-track 38, one load of track 19 after settling
        i_mtr = 1'b1;
        step(2'd1); step(2'd2); step(2'd3); step(2'd0);
        check("in4_half", int'(o_half_track), 38);
        serve(1'b0, 19, "in4_load", 1'b1, lat);
        check("in4_lat", int'(lat >= ST), 1);

        // dirty track 19, step out to 36: save 19 then load 18
        pulse_dirty();
        step(2'd3); step(2'd2);
        check("out2_half", int'(o_half_track), 36);
        serve(1'b1, 19, "save19", 1'b1, lat);
        serve(1'b0, 18, "load18", 1'b1, lat);
        repeat (ST + 10) tick();
        check("after_save_idle", int'(o_busy), 0);

        // bump at track 0, +2 jump, motor off, saturation at the top
        i_img_present = 1'b0;
        cur = 2'd2;
        for (int i = 0; i < 40; i++) begin
            cur = cur - 2'd1;
            step(cur);
        end
        check("bump_half", int'(o_half_track), 0);
        check("bump_tr00", int'(o_tr00_sense_n), 0);
        cur = cur + 2'd2;
        step(cur);
        check("jump_half", int'(o_half_track), 0);
        i_mtr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur = cur + 2'd1;
            step(cur);
        end
        check("mtr_off_half", int'(o_half_track), 0);
        i_mtr = 1'b1;
        cur = cur + 2'd1;
        step(cur);
        check("leave0_half", int'(o_half_track), 1);
        check("leave0_tr00", int'(o_tr00_sense_n), 1);
        for (int i = 0; i < 90; i++) begin
            cur = cur + 2'd1;
            step(cur);
        end
        check("top_half", int'(o_half_track), MAXH);
        cur = cur - 2'd1;
        step(cur);
        check("top_back", int'(o_half_track), MAXH - 1);
        check("nopres_idle", int'(o_busy), 0);

        // step decode vector table from a fresh reset
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) begin
            i_stp = tbl[i].stp;
            i_mtr = tbl[i].mtr;
            i_ce = tbl[i].ce;
            tick();
            check($sformatf("vec%0d_half", i), int'(o_half_track), tbl[i].half);
            check($sformatf("vec%0d_tr00", i), int'(o_tr00_sense_n), int'(tbl[i].half != 0));
        end
        i_ce = 1'b1;

        // steps during a load do not disturb it; the new track follows via settle
        do_reset(1'b1);
        i_mtr = 1'b1;
        serve(1'b0, 17, "ld17", 1'b0, lat);
        step(2'd1); step(2'd2);
        repeat (3) tick();
        check("ld_hold_rd", int'(o_sd_rd), 1);
        check("ld_hold_track", int'(o_sd_track), 17);
        check("ld_hold_half", int'(o_half_track), 36);
        i_sd_ack = 1'b1;
        tick();
        i_sd_ack = 1'b0;
        check("ld17_drop", int'(o_sd_rd), 0);
        serve(1'b0, 18, "ld18", 1'b1, lat);
        check("ld18_lat", int'(lat >= ST), 1);

        // a mount discards dirty data; a mount mid-load forces another load
        pulse_dirty();
        pulse_mount();
        serve(1'b0, 18, "mnt_load", 1'b0, lat);
        pulse_mount();
        check("mnt_mid_rd", int'(o_sd_rd), 1);
        i_sd_ack = 1'b1;
        tick();
        i_sd_ack = 1'b0;
        check("mnt_mid_drop", int'(o_sd_rd), 0);
        serve(1'b0, 18, "mnt_reload", 1'b0, lat);
        #2 i_reset = 1'b1;
        #1;
        check("async_rst_rd", int'(o_sd_rd), 0);
        check("async_rst_half", int'(o_half_track), 34);
        check("async_rst_busy", int'(o_busy), 0);

        // randomized run: alternating stepping bursts and quiet periods
        i_stp = 2'd0;
        i_mtr = 1'b0;
        i_img_present = 1'b1;
        tick();
        i_reset = 1'b0;
        mh = 34;
        mp = 2'd0;
        for (int n = 0; n < 6000; n++) begin
            r = int'($urandom_range(0, 9));
            if ((n / 150) % 2 == 0)
                i_stp = i_stp + (r < 4 ? 2'd1 : r < 8 ? 2'd3 : r == 8 ? 2'd2 : 2'd0);
            i_ce = $urandom_range(0, 3) != 0;
            i_mtr = $urandom_range(0, 9) != 0;
            i_dirty_set = $urandom_range(0, 40) == 0;
            i_img_mounted = $urandom_range(0, 400) == 0;
            if ($urandom_range(0, 500) == 0)
                i_img_present = ~i_img_present;
            i_sd_ack = (o_sd_rd | o_sd_wr) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 30) == 0);
            if (i_ce) begin
                d = i_stp - mp;
                if (i_mtr && d == 2'd1 && mh < MAXH)
                    mh++;
                else if (i_mtr && d == 2'd3 && mh > 0)
                    mh--;
                mp = i_stp;
            end
            ord = o_sd_rd;
            owr = o_sd_wr;
            otr = o_sd_track;
            ack = i_sd_ack;
            tick();
            check("rnd_half", int'(o_half_track), mh);
            check("rnd_tr00", int'(o_tr00_sense_n), int'(mh != 0));
            check("rnd_both", int'(o_sd_rd & o_sd_wr), 0);
            if ((o_sd_rd | o_sd_wr))
                check("rnd_busy", int'(o_busy), 1);
            if (ord && !ack)
                check("rnd_rd_hold", int'(o_sd_rd), 1);
            if (owr && !ack)
                check("rnd_wr_hold", int'(o_sd_wr), 1);
            if ((ord | owr) && !ack)
                check("rnd_track_hold", int'(o_sd_track), int'(otr));
            if ((ord | owr) && ack)
                check("rnd_ack_drop", int'(o_sd_rd | o_sd_wr), 0);
        end
        i_sd_ack = 1'b0;
        i_dirty_set = 1'b0;
        i_img_mounted = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
